// File: rtl/vram_pkg.sv
// vram_pkg: geometry constants, line/word types and address split helpers for the tile VRAM.
package vram_pkg;
    localparam int TILE_LINES     = 2048;
    localparam int WORDS_PER_LINE = 16;
    localparam int WORD_W         = 16;
    localparam int LINE_W         = 256;
    localparam int READ_ADDR_W    = 12;
    localparam int WRITE_ADDR_W   = 15;
    localparam int LINE_IDX_W     = 11;
    typedef logic [LINE_W-1:0] tile_line_t;
    typedef logic [WORD_W-1:0] pixel_pair_t;
    function automatic logic [LINE_IDX_W-1:0] line_of(input logic [WRITE_ADDR_W-1:0] a);
        return a[WRITE_ADDR_W-1:4];
    endfunction
    function automatic logic [3:0] slot_of(input logic [WRITE_ADDR_W-1:0] a);
        return a[3:0];
    endfunction
endpackage

// File: rtl/vram_tile_bank.sv
// vram_tile_bank: 2048x16 simple dual-port block RAM with registered, clearable read output.
// Same-line write forwarding is enabled by VRAM_TILE_WRITE_FWD_EN; read-first otherwise.
module vram_tile_bank
    import vram_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic                  we,
    input  logic [LINE_IDX_W-1:0] waddr,
    input  pixel_pair_t           wdata,
    input  logic [LINE_IDX_W-1:0] raddr,
    output pixel_pair_t           rdata
);
    pixel_pair_t mem [TILE_LINES];
    pixel_pair_t rdata_d, rdata_q;
    always_comb begin
`ifdef VRAM_TILE_WRITE_FWD_EN
        rdata_d = (we && waddr == raddr) ? wdata : mem[raddr];
`else
        rdata_d = mem[raddr];
`endif
    end
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (reset || !rd_en) rdata_q <= '0;
        else rdata_q <= rdata_d;
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/vram_tile_memory.sv
// vram_tile_memory: 2048 x 256-bit sprite-line VRAM written 16 bits at a time, read a line per cycle.
// Optional write-first forwarding on read/write collisions via VRAM_TILE_WRITE_FWD_EN.
module vram_tile_memory
    import vram_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [READ_ADDR_W-1:0]  read_addr,
    input  logic [WRITE_ADDR_W-1:0] write_addr,
    input  pixel_pair_t             write_data,
    input  logic                    write_enable,
    output tile_line_t              read_data
);
    // Upper read address bit marks out-of-range lines: those read as zero without touching storage.
    logic rd_en;
    assign rd_en = ~read_addr[READ_ADDR_W-1];
    for (genvar k = 0; k < WORDS_PER_LINE; k++) begin : g_bank
        logic we;
        assign we = write_enable & ~reset & (slot_of(write_addr) == 4'(k));
        vram_tile_bank u_bank (
            .clk   (clk),
            .reset (reset),
            .rd_en (rd_en),
            .we    (we),
            .waddr (line_of(write_addr)),
            .wdata (write_data),
            .raddr (read_addr[LINE_IDX_W-1:0]),
            .rdata (read_data[WORD_W*k +: WORD_W])
        );
    end
endmodule

// File: tb/tb_vram_tile_memory.sv
// tb_vram_tile_memory: scoreboard bench with a word-level memory model and a table of line reads.
module tb_vram_tile_memory;
    import vram_pkg::*;
    logic        clk = 0;
    logic        reset = 1;
    logic [11:0] read_addr = 12'h800;
    logic [14:0] write_addr = '0;
    pixel_pair_t write_data = '0;
    logic        write_enable = 0;
    tile_line_t  read_data;
    pixel_pair_t model [32768];
    tile_line_t  sb [$];
    int n_chk = 0;
    int n_fail = 0;
    typedef struct {
        logic [11:0] ra;
        tile_line_t  exp;
    } vec_t;
    vec_t vecs [8];
    logic [11:0] ras [8] = '{12'h001, 12'h002, 12'h000, 12'h7FF, 12'h800, 12'h7FF, 12'hFFF, 12'h064};

    vram_tile_memory dut (
        .clk          (clk),
        .reset        (reset),
        .read_addr    (read_addr),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_data    (read_data)
    );

    always #5 clk = ~clk;

    function automatic tile_line_t model_line(input int l);
        tile_line_t r;
        for (int k = 0; k < 16; k++) r[16*k +: 16] = model[l*16 + k];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_line(input string name, input tile_line_t exp);
        tile_line_t e;
        sb.push_back(exp);
        step();
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, read_data=%h", name, read_data);
        end else begin
            e = sb.pop_front();
            if (read_data !== e) begin
                n_fail++;
                $display("FAIL %s: read_data=%h expected=%h", name, read_data, e);
            end
        end
    endtask

    initial begin
        tile_line_t old;
        check_line("reset0", '0);
        check_line("reset1", '0);
        reset = 0;
        write_enable = 1;
        for (int i = 0; i < 32768; i++) begin
            write_addr = 15'(i);
            write_data = 16'($urandom);
            model[i] = write_data;
            step();
        end
        write_enable = 0;
        check_line("fill_oor_idle", '0);
        for (int i = 0; i < 8; i++) begin
            vecs[i].ra = ras[i];
            vecs[i].exp = ras[i][11] ? '0 : model_line(int'(ras[i][10:0]));
        end
        for (int i = 0; i < 8; i++) begin
            read_addr = vecs[i].ra;
            check_line($sformatf("vec%0d_ra%h", i, vecs[i].ra), vecs[i].exp);
        end
        read_addr = 12'h001;
        check_line("hold_a", model_line(1));
        check_line("hold_b", model_line(1));
        read_addr = 12'h800;
        write_enable = 1;
        write_addr = 15'h0023;
        write_data = 16'hBEEF;
        model[16'h0023] = 16'hBEEF;
        check_line("partial_write_oor", '0);
        write_enable = 0;
        read_addr = 12'h002;
        check_line("partial_line2", model_line(2));
        n_chk++;
        if (read_data[63:48] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL partial_slot3: got=%h expected=%h", read_data[63:48], 16'hBEEF);
        end
        old = model_line(5);
        read_addr = 12'h005;
        write_enable = 1;
        write_addr = 15'd80;
        write_data = 16'h1234;
`ifdef VRAM_TILE_WRITE_FWD_EN
        old[15:0] = 16'h1234;
`endif
        model[80] = 16'h1234;
        check_line("collision", old);
        write_enable = 0;
        check_line("after_collision", model_line(5));
        read_addr = 12'h000;
        reset = 1;
        write_enable = 1;
        write_addr = '0;
        write_data = 16'hFFFF;
        check_line("rst_wr0", '0);
        check_line("rst_wr1", '0);
        reset = 0;
        write_enable = 0;
        check_line("post_reset_line0", model_line(0));
        read_addr = 12'h7FF;
        check_line("post_reset_last", model_line(2047));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
